// File: rtl/uart_pkg.sv
// Shared register map, control/status bit positions and FSM state types for the APB UART.
package uart_pkg;

   localparam logic [7:0] ADDR_DATA   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_CTRL   = 8'h08;
   localparam logic [7:0] ADDR_DIV_LO = 8'h0C;
   localparam logic [7:0] ADDR_DIV_HI = 8'h10;

   localparam int unsigned CTRL_TX_EN    = 0;
   localparam int unsigned CTRL_RX_EN    = 1;
   localparam int unsigned CTRL_PAR_EN   = 2;
   localparam int unsigned CTRL_PAR_ODD  = 3;
   localparam int unsigned CTRL_LOOPBACK = 4;
   localparam int unsigned CTRL_IRQ_RX   = 5;
   localparam int unsigned CTRL_IRQ_TX   = 6;

   localparam int unsigned ST_TX_FULL  = 0;
   localparam int unsigned ST_TX_EMPTY = 1;
   localparam int unsigned ST_RX_FULL  = 2;
   localparam int unsigned ST_RX_EMPTY = 3;
   localparam int unsigned ST_OVERRUN  = 4;
   localparam int unsigned ST_PAR_ERR  = 5;
   localparam int unsigned ST_FRM_ERR  = 6;
   localparam int unsigned ST_TX_BUSY  = 7;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; push while full is accepted only alongside a pop.
module uart_sync_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/apb_uart_core.sv
// APB-slave UART: programmable divisor, char width, optional parity, sticky errors,
// level irq and internal loopback. Single PCLK domain.
module apb_uart_core
   import uart_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned TX_DEPTH  = 16,
   parameter int unsigned RX_DEPTH  = 16,
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned DIV_RESET = 433
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   input  logic       rxd,
   output logic       txd,
   output logic       irq
);
   logic [6:0]       ctrl;
   logic [DIV_W-1:0] div_reg;
   logic             overrun, parity_err, frame_err;
   logic             setup, access, status_rd;
   logic [7:0]       status, rd_mux;

   logic              tx_push, tx_pop, tx_full, tx_empty, tx_tick, tx_par, tx_serial;
   logic [DATA_W-1:0] tx_dout, tx_shift;
   logic [DIV_W-1:0]  tx_cnt;
   logic [2:0]        tx_idx;
   tx_state_t         tx_state, tx_next;

   logic              rx_push, rx_pop, rx_full, rx_empty, rx_tick, rx_in, rx_prev;
   logic              rx_stop_ok, rx_stop_bad, rx_par_bad;
   logic [1:0]        rx_sync;
   logic [DATA_W-1:0] rx_dout, rx_shift;
   logic [DIV_W-1:0]  rx_cnt;
   logic [2:0]        rx_idx;
   rx_state_t         rx_state, rx_next;

   assign PREADY    = 1'b1;
   assign setup     = PSEL & ~PENABLE;
   assign access    = PSEL & PENABLE;
   assign status_rd = setup & ~PWRITE & (PADDR == ADDR_STATUS);
   assign rx_pop    = setup & ~PWRITE & (PADDR == ADDR_DATA);
   assign tx_push   = access & PWRITE & (PADDR == ADDR_DATA);

   always_comb begin
      status              = '0;
      status[ST_TX_FULL]  = tx_full;
      status[ST_TX_EMPTY] = tx_empty;
      status[ST_RX_FULL]  = rx_full;
      status[ST_RX_EMPTY] = rx_empty;
      status[ST_OVERRUN]  = overrun;
      status[ST_PAR_ERR]  = parity_err;
      status[ST_FRM_ERR]  = frame_err;
      status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
   end

   always_comb begin
      rd_mux = '0;
      case (PADDR)
         ADDR_DATA:   rd_mux = rx_empty ? 8'h00 : 8'(rx_dout);
         ADDR_STATUS: rd_mux = status;
         ADDR_CTRL:   rd_mux = {1'b0, ctrl};
         ADDR_DIV_LO: rd_mux = div_reg[7:0];
         ADDR_DIV_HI: rd_mux = 8'(div_reg >> 8);
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         PRDATA  <= '0;
         PSLVERR <= 1'b0;
         ctrl    <= 7'h03;
         div_reg <= DIV_W'(DIV_RESET);
      end else begin
         if (setup) begin
            case (PADDR)
               ADDR_DATA:                                  PSLVERR <= PWRITE ? tx_full : rx_empty;
               ADDR_STATUS, ADDR_CTRL, ADDR_DIV_LO, ADDR_DIV_HI: PSLVERR <= 1'b0;
               default:                                    PSLVERR <= 1'b1;
            endcase
            if (!PWRITE) PRDATA <= rd_mux;
         end else if (!access) begin
            PSLVERR <= 1'b0;
         end
         if (access && PWRITE) begin
            case (PADDR)
               ADDR_CTRL:   ctrl         <= PWDATA[6:0];
               ADDR_DIV_LO: div_reg[7:0] <= PWDATA;
               ADDR_DIV_HI: div_reg      <= {PWDATA[DIV_W-9:0], div_reg[7:0]};
               default: ;
            endcase
         end
      end
   end

   uart_sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop), .din(PWDATA[DATA_W-1:0]),
      .dout(tx_dout), .full(tx_full), .empty(tx_empty));

   uart_sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk(PCLK), .rst(PRESET), .push(rx_push & ~rx_full), .pop(rx_pop), .din(rx_shift),
      .dout(rx_dout), .full(rx_full), .empty(rx_empty));

   // ---------------- transmitter ----------------
   assign tx_tick = (tx_cnt == '0);

   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      case (tx_state)
         TX_IDLE: if (ctrl[CTRL_TX_EN] && !tx_empty) begin
            tx_next = TX_START;
            tx_pop  = 1'b1;
         end
         TX_START:  if (tx_tick) tx_next = TX_DATA;
         TX_DATA:   if (tx_tick && tx_idx == 3'(DATA_W-1))
                       tx_next = ctrl[CTRL_PAR_EN] ? TX_PARITY : TX_STOP;
         TX_PARITY: if (tx_tick) tx_next = TX_STOP;
         TX_STOP:   if (tx_tick) tx_next = TX_IDLE;
         default:   tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) tx_state <= TX_IDLE;
      else        tx_state <= tx_next;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
      end else if (tx_pop) begin
         tx_cnt   <= div_reg;
         tx_idx   <= '0;
         tx_shift <= tx_dout;
         tx_par   <= ^tx_dout ^ ctrl[CTRL_PAR_ODD];
      end else if (tx_state != TX_IDLE) begin
         if (tx_tick) begin
            tx_cnt <= div_reg;
            if (tx_state == TX_DATA) tx_idx <= tx_idx + 1'b1;
         end else begin
            tx_cnt <= tx_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      case (tx_state)
         TX_START:  tx_serial = 1'b0;
         TX_DATA:   tx_serial = tx_shift[tx_idx];
         TX_PARITY: tx_serial = tx_par;
         default:   tx_serial = 1'b1;
      endcase
   end

   assign txd = ctrl[CTRL_LOOPBACK] | tx_serial;

   // ---------------- receiver ----------------
   assign rx_in       = ctrl[CTRL_LOOPBACK] ? tx_serial : rx_sync[1];
   assign rx_tick     = (rx_cnt == '0);
   assign rx_stop_ok  = ctrl[CTRL_RX_EN] & (rx_state == RX_STOP) & rx_tick & rx_in;
   assign rx_stop_bad = ctrl[CTRL_RX_EN] & (rx_state == RX_STOP) & rx_tick & ~rx_in;
   assign rx_par_bad  = ctrl[CTRL_RX_EN] & (rx_state == RX_PARITY) & rx_tick &
                        (rx_in != (^rx_shift ^ ctrl[CTRL_PAR_ODD]));
   assign rx_push     = rx_stop_ok;

   always_comb begin
      rx_next = rx_state;
      if (!ctrl[CTRL_RX_EN]) begin
         rx_next = RX_IDLE;
      end else begin
         case (rx_state)
            RX_IDLE:   if (rx_prev && !rx_in) rx_next = RX_START;
            RX_START:  if (rx_tick) rx_next = rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == 3'(DATA_W-1))
                          rx_next = ctrl[CTRL_PAR_EN] ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP:   if (rx_tick) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) rx_state <= RX_IDLE;
      else        rx_state <= rx_next;
   end

   // The idle reload of div/2 places the start-bit sample mid-bit after the detected edge.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_cnt   <= '0;
         rx_idx   <= '0;
         rx_shift <= '0;
      end else begin
         rx_sync <= {rx_sync[0], rxd};
         rx_prev <= rx_in;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= div_reg >> 1;
            rx_idx <= '0;
         end else if (rx_tick) begin
            rx_cnt <= div_reg;
            if (rx_state == RX_DATA) begin
               rx_shift <= {rx_in, rx_shift[DATA_W-1:1]};
               rx_idx   <= rx_idx + 1'b1;
            end
         end else begin
            rx_cnt <= rx_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         overrun    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (status_rd) begin
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
         end
         if (rx_push && rx_full) overrun    <= 1'b1;
         if (rx_par_bad)         parity_err <= 1'b1;
         if (rx_stop_bad)        frame_err  <= 1'b1;
         irq <= (ctrl[CTRL_IRQ_RX] & ~rx_empty) | (ctrl[CTRL_IRQ_TX] & tx_empty);
      end
   end
endmodule

// File: tb/tb_apb_uart_core.sv
// Directed bench for apb_uart_core: register access, loopback, parity/frame/overrun errors.
module tb_apb_uart_core;
   logic       PCLK = 1'b0, PRESET = 1'b1;
   logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0] PADDR = '0, PWDATA = '0;
   logic [7:0] PRDATA;
   logic       PREADY, PSLVERR;
   logic       rxd = 1'b1;
   logic       txd, irq;

   int unsigned checks = 0, failures = 0;
   int unsigned bit_clks = 4;
   logic [7:0]  rdata;
   logic        err;

   apb_uart_core #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16), .DIV_W(16), .DIV_RESET(433)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .rxd(rxd), .txd(txd), .irq(irq));

   always #5 PCLK = ~PCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic clks(input int unsigned n);
      repeat (n) @(posedge PCLK);
      #1;
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      e = PSLVERR;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      d = PRDATA; e = PSLVERR;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // Drives one 8-bit frame on rxd, bit_clks PCLKs per bit.
   task automatic rx_frame(input logic [7:0] d, input logic with_par, input logic par,
                           input logic stop);
      logic [7:0] v;
      v = d;
      @(posedge PCLK); #1;
      rxd = 1'b0; clks(bit_clks);
      for (int i = 0; i < 8; i++) begin
         rxd = v[i]; clks(bit_clks);
      end
      if (with_par) begin
         rxd = par; clks(bit_clks);
      end
      rxd = stop; clks(bit_clks);
      rxd = 1'b1;
   endtask

   initial begin
      clks(4);
      check("rst_prdata", PRDATA, 8'h00);
      check("rst_txd", txd, 1'b1);
      check("rst_irq", irq, 1'b0);
      check("rst_pslverr", PSLVERR, 1'b0);
      PRESET = 1'b0;
      clks(2);

      apb_read(8'h04, rdata, err); check("rst_status", rdata, 8'h0A);
      apb_read(8'h08, rdata, err); check("rst_ctrl", rdata, 8'h03);
      apb_read(8'h0C, rdata, err); check("rst_div_lo", rdata, 8'hB1);
      apb_read(8'h10, rdata, err); check("rst_div_hi", rdata, 8'h01);

      apb_read(8'h14, rdata, err);
      check("unmapped_rd_data", rdata, 8'h00);
      check("unmapped_rd_err", err, 1'b1);
      apb_write(8'h20, 8'h55, err); check("unmapped_wr_err", err, 1'b1);

      // loopback 0xA5 at DIV=3
      apb_write(8'h0C, 8'h03, err);
      apb_write(8'h10, 8'h00, err);
      apb_write(8'h08, 8'h33, err); check("ctrl_wr_err", err, 1'b0);
      apb_write(8'h00, 8'hA5, err); check("tx_wr_err", err, 1'b0);
      check("loop_txd_idle", txd, 1'b1);
      clks(60);
      check("loop_irq", irq, 1'b1);
      apb_read(8'h04, rdata, err); check("loop_status", rdata, 8'h02);
      apb_read(8'h00, rdata, err);
      check("loop_data", rdata, 8'hA5);
      check("loop_err", err, 1'b0);
      clks(1);
      check("loop_irq_clr", irq, 1'b0);
      apb_read(8'h00, rdata, err);
      check("empty_rd_data", rdata, 8'h00);
      check("empty_rd_err", err, 1'b1);

      // even parity over external rxd
      apb_write(8'h08, 8'h06, err);
      rx_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      clks(10);
      apb_read(8'h04, rdata, err); check("par_ok_status", rdata, 8'h02);
      apb_read(8'h00, rdata, err); check("par_ok_data", rdata, 8'h3C);
      rx_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      clks(10);
      apb_read(8'h04, rdata, err); check("par_err_status", rdata, 8'h22);
      apb_read(8'h04, rdata, err); check("par_err_cleared", rdata, 8'h02);
      apb_read(8'h00, rdata, err); check("par_err_data", rdata, 8'h3C);

      // TX overflow with tx_en=0, then drain through loopback into RX and overrun it
      apb_write(8'h08, 8'h02, err);
      for (int i = 0; i < 17; i++) begin
         apb_write(8'h00, 8'(8'h40 + i), err);
         if (i == 0)  check("txfill_first_err", err, 1'b0);
         if (i == 16) check("txfill_last_err", err, 1'b1);
      end
      apb_read(8'h04, rdata, err); check("tx_full_status", rdata, 8'h09);
      apb_write(8'h08, 8'h13, err);
      clks(720);
      apb_read(8'h04, rdata, err); check("rx_full_status", rdata, 8'h06);
      apb_write(8'h00, 8'h77, err);
      clks(60);
      apb_read(8'h04, rdata, err); check("overrun_status", rdata, 8'h16);
      apb_read(8'h04, rdata, err); check("overrun_cleared", rdata, 8'h06);
      for (int i = 0; i < 16; i++) begin
         apb_read(8'h00, rdata, err);
         check($sformatf("drain_%0d", i), rdata, 8'(8'h40 + i));
      end
      apb_read(8'h00, rdata, err); check("drain_end_err", err, 1'b1);

      // glitch and framing error at DIV=7
      apb_write(8'h08, 8'h02, err);
      apb_write(8'h0C, 8'h07, err);
      bit_clks = 8;
      @(posedge PCLK); #1;
      rxd = 1'b0; clks(1); rxd = 1'b1;
      clks(30);
      apb_read(8'h04, rdata, err); check("glitch_status", rdata, 8'h0A);
      rx_frame(8'h55, 1'b0, 1'b0, 1'b0);
      clks(20);
      apb_read(8'h04, rdata, err); check("frame_err_status", rdata, 8'h4A);
      apb_read(8'h04, rdata, err); check("frame_err_cleared", rdata, 8'h0A);

      // reset in the middle of a frame returns txd high
      apb_write(8'h08, 8'h01, err);
      apb_write(8'h00, 8'h00, err);
      clks(20);
      check("midframe_txd_low", txd, 1'b0);
      PRESET = 1'b1;
      clks(1);
      check("midframe_rst_txd", txd, 1'b1);
      PRESET = 1'b0;
      clks(2);
      apb_read(8'h04, rdata, err); check("post_rst_status", rdata, 8'h0A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
